fft64_reorder: RTL

Output reorder stage placed directly downstream of the 64-point FFT in the one-seg demodulator. It accepts the FFT's bit-reversed output stream, one complex bin per valid cycle, and buffers each 64-bin symbol in a ping-pong RAM. It then re-emits the symbol in natural bin order (0..63), with a bin index and start-of-frame marker, to the carrier demapper.

---
 rtl/fft64_pkg.sv | 22 ++
 rtl/fft64_reorder_ram.sv | 33 +++
 rtl/fft64_reorder.sv | 119 +++++++++++
 3 files changed

// File: rtl/fft64_pkg.sv
// Shared constants and helpers for the 64-point FFT datapath.
//   N       : points per frame
//   LOG2N   : address bits per frame
//   bitrev6 : reverses the 6 index bits (FFT output order <-> natural order)
//   rd_state_t : read-side FSM states of the reorder stage
package fft64_pkg;

  localparam int N     = 64;
  localparam int LOG2N = 6;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev6(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft64_reorder_ram.sv
// Ping-pong frame buffer: simple dual-port RAM, two banks of N words.
// The address MSB selects the bank. The read port is registered, so data
// appears one cycle after re_i. There is no reset, which lets it map onto
// block RAM.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request
//   rdata_o          : read data, one cycle after re_i
module reorder_ram
  import fft64_pkg::*;
#(
  parameter int DW = 17
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [LOG2N:0]  waddr_i,
  input  logic [2*DW-1:0] wdata_i,
  input  logic            re_i,
  input  logic [LOG2N:0]  raddr_i,
  output logic [2*DW-1:0] rdata_o
);

  logic [2*DW-1:0] mem [2*N];
  logic [2*DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft64_reorder.sv
// FFT output reorder stage. It accepts bit-reversed bins, one per valid
// cycle, and writes each bin to its natural-order slot in the current write
// bank. It then drains every completed bank in natural order (0..N-1).
//   CLK, RST        : clock, async active-high reset
//   valid_i, xr, xi : input bin stream (no backpressure)
//   flush           : drop the partially written frame
//   valid_o, yr, yi : output bin stream, natural order
//   idx_o           : natural bin index of yr/yi
//   sof_o           : high with bin 0 of each frame
module fft64_reorder #(
  parameter int DW = 17,
  parameter int N  = 64
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           valid_i,
  input  logic signed [DW-1:0]           xr,
  input  logic signed [DW-1:0]           xi,
  input  logic                           flush,
  output logic                           valid_o,
  output logic signed [DW-1:0]           yr,
  output logic signed [DW-1:0]           yi,
  output logic [fft64_pkg::LOG2N-1:0]    idx_o,
  output logic                           sof_o
);

  import fft64_pkg::*;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, iss_idx_q, idx_q;
  logic             wbank_q, wbank_d, rbank_q;
  logic [1:0]       full_q, full_d;
  rd_state_t        state_q;
  logic [1:0]       vld_pipe_q;   // [0]: RAM read in flight, [1]: output valid
  logic             we, wrap, rd_en, rd_last, sof_q;
  logic [DW-1:0]    yr_q, yi_q;
  logic [2*DW-1:0]  rd_data;

  always_comb begin
    we      = valid_i && !flush;            // flush wins over a same-cycle sample
    wrap    = we && (wcnt_q == LAST);
    // A full read bank is drained one word per cycle. The read that starts
    // a frame is issued on the IDLE->READ edge, and the read after a bank
    // release is issued in the next cycle from either state. Neither case
    // leaves a bubble between frames.
    rd_en   = full_q[rbank_q];
    rd_last = rd_en && (rcnt_q == LAST);

    wcnt_d = wcnt_q;
    if (flush)   wcnt_d = '0;
    else if (we) wcnt_d = wcnt_q + 1'b1;
    wbank_d = wbank_q ^ wrap;

    // Writer completion and reader release touch independent flags.
    full_d = full_q;
    if (rd_last) full_d[rbank_q] = 1'b0;
    if (wrap)    full_d[wbank_q] = 1'b1;
  end

  reorder_ram #(.DW(DW)) u_ram (
    .clk_i   (CLK),
    .we_i    (we),
    .waddr_i ({wbank_q, bitrev6(wcnt_q)}),
    .wdata_i ({xr, xi}),
    .re_i    (rd_en),
    .raddr_i ({rbank_q, rcnt_q}),
    .rdata_o (rd_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q     <= '0;
      wbank_q    <= 1'b0;
      full_q     <= '0;
      rcnt_q     <= '0;
      rbank_q    <= 1'b0;
      state_q    <= RD_IDLE;
      vld_pipe_q <= '0;
      iss_idx_q  <= '0;
      yr_q       <= '0;
      yi_q       <= '0;
      idx_q      <= '0;
      sof_q      <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;

      // rcnt wraps to 0 by itself after the last word of a bank.
      if (rd_en)   rcnt_q  <= rcnt_q + 1'b1;
      if (rd_last) rbank_q <= ~rbank_q;

      case (state_q)
        RD_IDLE: if (rd_en) state_q <= RD_READ;
        RD_READ: if (rd_last && !full_d[~rbank_q]) state_q <= RD_IDLE;
        default: state_q <= RD_IDLE;
      endcase

      vld_pipe_q <= {vld_pipe_q[0], rd_en};
      iss_idx_q  <= rcnt_q;
      if (vld_pipe_q[0]) begin
        yr_q  <= rd_data[2*DW-1:DW];
        yi_q  <= rd_data[DW-1:0];
        idx_q <= iss_idx_q;
        sof_q <= (iss_idx_q == '0);
      end else begin
        sof_q <= 1'b0;
      end
    end
  end

  assign valid_o = vld_pipe_q[1];
  assign yr      = yr_q;
  assign yi      = yi_q;
  assign idx_o   = idx_q;
  assign sof_o   = sof_q;

endmodule
